regfile_wb_arbiter: RTL and testbench

//  Shares the single register-file write port among NUM_REQ writeback requesters (ALU, load, CSR, ...).

---
 rtl/regfile_wb_arbiter.sv | 113 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin arbiter sharing the register-file write port among writeback sources
// Optional forwarding of the staged write is enabled by defining WB_FWD_EN.
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16,
    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
    output logic [NUM_REQ-1:0]        o_req_ready,
    output logic                      o_write_enable,
    output logic [ADDR_W-1:0]         o_write_addr,
    output logic [DATA_W-1:0]         o_write_data,
    output logic [ID_W-1:0]           o_grant_id,
`ifdef WB_FWD_EN
    input  logic [ADDR_W-1:0]         i_fwd_addr1,
    input  logic [ADDR_W-1:0]         i_fwd_addr2,
    output logic                      o_fwd_hit1,
    output logic                      o_fwd_hit2,
    output logic [DATA_W-1:0]         o_fwd_data1,
    output logic [DATA_W-1:0]         o_fwd_data2,
`endif
    output logic [CNT_W-1:0]          o_conflict_cnt
);

    logic [ID_W-1:0]   r_rr_ptr;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [ID_W-1:0]   r_gid;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_found;
    logic [ID_W-1:0]   w_gnt_idx;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;
    logic [NUM_REQ-1:0] w_ready;
    logic              w_accept;
    logic              w_multi;
    int                w_cand;

    // Search starts at the round-robin pointer and wraps; first valid requester wins.
    always_comb begin
        w_found    = 1'b0;
        w_gnt_idx  = '0;
        w_sel_addr = '0;
        w_sel_data = '0;
        w_cand     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = (int'(r_rr_ptr) + k) % NUM_REQ;
            if (!w_found && i_req_valid[w_cand]) begin
                w_found    = 1'b1;
                w_gnt_idx  = ID_W'(w_cand);
                w_sel_addr = i_req_addr[w_cand*ADDR_W +: ADDR_W];
                w_sel_data = i_req_data[w_cand*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        w_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_ready[i] = w_found && !i_rst && (int'(w_gnt_idx) == i);
        end
    end

    assign w_accept = w_found && !i_rst;
    // Clearing the lowest set bit leaves something only when two or more requests are valid.
    assign w_multi  = (i_req_valid & (i_req_valid - NUM_REQ'(1))) != '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
            r_gid    <= '0;
            r_rr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            // Writes to x0 are consumed but never reach the register file.
            r_we <= w_accept && (w_sel_addr != '0);
            if (w_accept) begin
                r_addr   <= w_sel_addr;
                r_data   <= w_sel_data;
                r_gid    <= w_gnt_idx;
                r_rr_ptr <= ID_W'((int'(w_gnt_idx) + 1) % NUM_REQ);
            end
            if (w_multi && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_req_ready    = w_ready;
    assign o_write_enable = r_we;
    assign o_write_addr   = r_addr;
    assign o_write_data   = r_data;
    assign o_grant_id     = r_gid;
    assign o_conflict_cnt = r_cnt;

`ifdef WB_FWD_EN
    assign o_fwd_hit1  = r_we && (r_addr == i_fwd_addr1) && (i_fwd_addr1 != '0);
    assign o_fwd_hit2  = r_we && (r_addr == i_fwd_addr2) && (i_fwd_addr2 != '0);
    assign o_fwd_data1 = o_fwd_hit1 ? r_data : '0;
    assign o_fwd_data2 = o_fwd_hit2 ? r_data : '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 32;
    localparam int CNT_W   = 4;
    localparam int ID_W    = 2;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      write_enable;
    logic [ADDR_W-1:0]         write_addr;
    logic [DATA_W-1:0]         write_data;
    logic [ID_W-1:0]           grant_id;
    logic [CNT_W-1:0]          conflict_cnt;
`ifdef WB_FWD_EN
    logic [ADDR_W-1:0]         fwd_addr1, fwd_addr2;
    logic                      fwd_hit1, fwd_hit2;
    logic [DATA_W-1:0]         fwd_data1, fwd_data2;
`endif

    regfile_wb_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_req_valid(req_valid),
        .i_req_addr(req_addr),
        .i_req_data(req_data),
        .o_req_ready(req_ready),
        .o_write_enable(write_enable),
        .o_write_addr(write_addr),
        .o_write_data(write_data),
        .o_grant_id(grant_id),
`ifdef WB_FWD_EN
        .i_fwd_addr1(fwd_addr1),
        .i_fwd_addr2(fwd_addr2),
        .o_fwd_hit1(fwd_hit1),
        .o_fwd_hit2(fwd_hit2),
        .o_fwd_data1(fwd_data1),
        .o_fwd_data2(fwd_data2),
`endif
        .o_conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [ID_W-1:0]   gid;
    } wr_t;

    wr_t exp_q[$];
    wr_t m_stage;
    int  m_rr;
    int  m_cnt;
    int  checks;
    int  failures;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    // One clock: check grant mid-cycle, predict the staged write, compare after the edge.
    task automatic tick(input string tag);
        int   g;
        int   pc;
        logic [NUM_REQ-1:0] exp_ready;
        wr_t  e;
        @(negedge clk);
        g = -1;
        if (!rst) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (g < 0 && req_valid[(m_rr + k) % NUM_REQ]) g = (m_rr + k) % NUM_REQ;
            end
        end
        exp_ready = (g >= 0) ? NUM_REQ'(1 << g) : '0;
        check({tag, " ready"}, 64'(req_ready), 64'(exp_ready));
        pc = $countones(req_valid);
        @(posedge clk);
        if (rst) begin
            m_stage = '0;
            m_rr    = 0;
            m_cnt   = 0;
        end else begin
            if (pc >= 2 && m_cnt < (1 << CNT_W) - 1) m_cnt++;
            m_stage.we = 1'b0;
            if (g >= 0) begin
                m_stage.addr = req_addr[g*ADDR_W +: ADDR_W];
                m_stage.data = req_data[g*DATA_W +: DATA_W];
                m_stage.gid  = ID_W'(g);
                m_stage.we   = (m_stage.addr != '0);
                m_rr         = (g + 1) % NUM_REQ;
            end
        end
        exp_q.push_back(m_stage);
        #1;
        e = exp_q.pop_front();
        check({tag, " we"},   64'(write_enable), 64'(e.we));
        check({tag, " addr"}, 64'(write_addr),   64'(e.addr));
        check({tag, " data"}, 64'(write_data),   64'(e.data));
        check({tag, " gid"},  64'(grant_id),     64'(e.gid));
        check({tag, " cnt"},  64'(conflict_cnt), 64'(m_cnt));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick("reset");
        rst = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0;
        m_stage = '0; m_rr = 0; m_cnt = 0;
        rst = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;
`ifdef WB_FWD_EN
        fwd_addr1 = '0; fwd_addr2 = '0;
`endif
        @(posedge clk); #1;
        do_reset();
        check("reset we", 64'(write_enable), 64'(0));
        check("reset cnt", 64'(conflict_cnt), 64'(0));

        // single requester
        set_req(0, 5'd5, 32'hDEADBEEF);
        req_valid = 4'b0001;
        tick("t1");
        check("t1 we", 64'(write_enable), 64'(1));
        check("t1 addr", 64'(write_addr), 64'(5));
        check("t1 data", 64'(write_data), 64'hDEADBEEF);
        req_valid = '0;
        tick("t1 idle");
        check("t1 hold addr", 64'(write_addr), 64'(5));

        // full contention rotates through all requesters
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, ADDR_W'(i + 10), 32'hA000_0000 + 32'(i));
        req_valid = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            tick("t2");
            check("t2 order", 64'(grant_id), 64'(c % NUM_REQ));
        end
        check("t2 cnt", 64'(conflict_cnt), 64'(5));
        req_valid = '0;
        tick("t2 idle");

        // x0 write is consumed but suppressed
        do_reset();
        set_req(0, 5'd0, 32'h55);
        set_req(1, 5'd3, 32'h33);
        req_valid = 4'b0001;
        tick("t3 x0");
        check("t3 x0 we", 64'(write_enable), 64'(0));
        req_valid = 4'b0011;
        tick("t3 next");
        check("t3 gid", 64'(grant_id), 64'(1));
        req_valid = '0;
        tick("t3 idle");

        // reset mid-operation with everyone requesting
        for (int i = 0; i < NUM_REQ; i++) set_req(i, ADDR_W'(i + 20), 32'hB000_0000 + 32'(i));
        req_valid = 4'b1111;
        tick("t4 pre");
        tick("t4 pre");
        rst = 1'b1;
        tick("t4 rst");
        check("t4 rst we", 64'(write_enable), 64'(0));
        rst = 1'b0;
        tick("t4 post");
        check("t4 first gid", 64'(grant_id), 64'(0));
        req_valid = '0;
        tick("t4 idle");

        // saturating contention counter
        do_reset();
        set_req(1, 5'd1, 32'h11);
        set_req(2, 5'd2, 32'h22);
        req_valid = 4'b0110;
        for (int c = 0; c < 20; c++) tick("t5");
        check("t5 cnt sat", 64'(conflict_cnt), 64'(15));
        req_valid = '0;
        tick("t5 idle");
        check("t5 cnt hold", 64'(conflict_cnt), 64'(15));

`ifdef WB_FWD_EN
        do_reset();
        set_req(2, 5'd7, 32'h1234);
        req_valid = 4'b0100;
        fwd_addr1 = 5'd7;
        fwd_addr2 = 5'd0;
        tick("t6");
        check("t6 hit1", 64'(fwd_hit1), 64'(1));
        check("t6 data1", 64'(fwd_data1), 64'h1234);
        check("t6 hit2", 64'(fwd_hit2), 64'(0));
        check("t6 data2", 64'(fwd_data2), 64'(0));
        req_valid = '0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
